seven_segment_decoder: RTL
==========================

Name: seven_segment_decoder

Overview:
Inverse of the team's binary-to-7-segment encoder. Watches a time-multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and debounces each digit's pattern. Decodes each stable pattern back to its 4-bit value and presents a complete multi-digit snapshot over a valid/ready handshake. Used as a self-check monitor and loopback decoder for the score display path on the Go board.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical sampled cycles required before a digit is captured (2..255)
ACTIVE_LOW, 0, 1 = segment lines are active-low; inverted on input before decode

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
i_segments  input  7  segment lines, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
i_digit_en  input  NUM_DIGITS  one-hot digit enable; bit n selects digit n
i_err_clr  input  1  single-cycle pulse that clears sticky error flags
i_ready  input  1  consumer accepts the snapshot
o_valid  output  1  snapshot available
o_value  output  4*NUM_DIGITS  decoded nibbles; digit n at [4n+3:4n]
o_blank  output  NUM_DIGITS  digit n was captured as all-segments-off
o_code_err  output  1  sticky: a stable pattern was not in the code table
o_bus_err  output  1  sticky: more than one digit enable was asserted

Behaviour:
- Single clock domain. reset_n is sampled on the rising clk edge only and is active-low. While reset_n is low, all state and outputs clear: o_valid=0, o_value=0, o_blank=0, both error flags=0, fresh bits=0, run counter=0, FSM=COLLECT. Reset mid-handshake drops o_valid on the next edge and discards any partial capture.
- Input stage: i_segments (after ACTIVE_LOW inversion) and i_digit_en are registered once.
- Run counter: increments, saturating at STABLE_CYCLES, while the registered {segments, enables} equal the previous registered value and the enables are exactly one-hot. Otherwise it reloads to 1 (one-hot) or 0 (zero or multi-hot).
- Capture event: fires once when the run counter first reaches STABLE_CYCLES. No re-capture until the pattern or the enable changes.
- Capture timing: a capture for a pattern held at the pins from cycle k updates internal state at edge k+STABLE_CYCLES.
- Decode table (pattern -> nibble):
  7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F.
- Pattern 00: stored as value 0 with blank[n]=1.
- Any other pattern: sets o_code_err; the digit's stored value, blank bit and fresh bit are unchanged.
- A valid capture (table entry or 00) writes digit n's value and blank bit and sets fresh[n]; blank[n] is cleared on a table-entry capture.
- Zero-hot enable: no capture, no error.
- Multi-hot enable: no capture; sets o_bus_err.
- Error clear: i_err_clr clears both flags. If a set and a clear occur on the same cycle, the set wins.
- Snapshot FSM, two states:
  COLLECT: when all fresh bits are 1, load o_value/o_blank from the digit registers, assert o_valid, clear all fresh bits, go to HOLD. If a capture lands on the same edge, its fresh bit stays set and its new value is not part of this snapshot.
  HOLD: o_valid=1; o_value and o_blank are frozen. Captures continue into the digit registers and fresh bits. On o_valid & i_ready: o_valid falls next edge, go to COLLECT. If all fresh bits are already 1, the next snapshot loads one cycle after that, so back-to-back snapshots are two cycles apart minimum.
- Latency from the capture completing the set to o_valid high: 1 cycle.
- i_ready while o_valid=0 is ignored.
- Run counter width: ceil(log2(STABLE_CYCLES+1)). No other arithmetic.

Test Plan:
1. reset_n=0 for 3 cycles with random inputs -> all outputs 0. Then en=2'b01, seg=5B held -> capture at edge k+4, not before.
2. STABLE_CYCLES=4, i_ready=1: digit0 seg=5B for 6 cycles, then digit1 seg=4E for 6 cycles -> o_valid high for exactly 1 cycle, 1 cycle after digit1 capture, with o_value=8'hC5, o_blank=2'b00.
3. Glitch: digit0 seg=7F for 2 cycles, then 7B for 6 cycles; digit1 seg=00 for 6 cycles -> o_value=8'h09, o_blank=2'b10, no snapshot ever contains 8.
4. Stable illegal pattern 01 on digit0 -> o_code_err=1, fresh[0] not set, no o_valid. Pulse i_err_clr -> o_code_err=0 next edge. i_err_clr coincident with a new 01 capture -> o_code_err stays 1.
5. Backpressure: i_ready=0 with snapshot 8'h21 presented; drive both digits to 30 -> o_value stays 8'h21 until i_ready=1. After the handshake, o_valid drops for 1 cycle, then 8'h11 is presented.
6. en=2'b11 stable -> o_bus_err=1, no capture. Assert reset_n=0 while o_valid=1 -> o_valid=0 and o_bus_err=0 on the next edge.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// Loopback decoder for a time-multiplexed 7-segment display bus.
// Debounces each digit's segment pattern and decodes it back to a nibble.
// Presents a complete multi-digit snapshot over a valid/ready handshake.
module seven_segment_decoder #(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [6:0]                i_segments,
  input  logic [NUM_DIGITS-1:0]     i_digit_en,
  input  logic                      i_err_clr,
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic [4*NUM_DIGITS-1:0]   o_value,
  output logic [NUM_DIGITS-1:0]     o_blank,
  output logic                      o_code_err,
  output logic                      o_bus_err
);

  localparam int unsigned RW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                    state;
  logic [6:0]                seg_q, seg_p;
  logic [NUM_DIGITS-1:0]     en_q, en_p;
  logic [RW-1:0]             run, run_next;
  logic                      one_hot, multi_hot, same;
  logic                      capture, cap_ok, cap_bad;
  logic                      legal, blank_pat;
  logic [3:0]                nib;
  logic [NUM_DIGITS-1:0]     fresh, fresh_set;
  logic [4*NUM_DIGITS-1:0]   dig_val;
  logic [NUM_DIGITS-1:0]     dig_blk;

  // Register the bus once, and keep the previous registered sample for the stability compare
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q <= '0;
      en_q  <= '0;
      seg_p <= '0;
      en_p  <= '0;
    end else begin
      seg_q <= ACTIVE_LOW ? ~i_segments : i_segments;
      en_q  <= i_digit_en;
      seg_p <= seg_q;
      en_p  <= en_q;
    end
  end

  // Stability tracking, capture qualification and pattern decode
  always_comb begin
    one_hot   = $onehot(en_q);
    multi_hot = (en_q != '0) && !one_hot;
    same      = ({seg_q, en_q} == {seg_p, en_p});

    if (one_hot && same)
      run_next = (run == RW'(STABLE_CYCLES)) ? run : run + RW'(1);
    else if (one_hot)
      run_next = RW'(1);
    else
      run_next = '0;

    // Fires only on the cycle the run first reaches its target; saturation blocks re-capture
    capture = one_hot && same && (run == RW'(STABLE_CYCLES - 1));

    legal = 1'b1;
    nib   = 4'h0;
    case (seg_q)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: legal = 1'b0;
    endcase
    blank_pat = (seg_q == 7'h00);

    cap_ok    = capture && (legal || blank_pat);
    cap_bad   = capture && !legal && !blank_pat;
    fresh_set = cap_ok ? en_q : '0;
  end

  // Run counter, per-digit storage and sticky error flags (a set beats a same-cycle clear)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run        <= '0;
      dig_val    <= '0;
      dig_blk    <= '0;
      o_code_err <= 1'b0;
      o_bus_err  <= 1'b0;
    end else begin
      run <= run_next;
      if (cap_ok) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (en_q[i]) begin
            dig_val[4*i +: 4] <= nib;
            dig_blk[i]        <= blank_pat;
          end
        end
      end
      if (cap_bad)
        o_code_err <= 1'b1;
      else if (i_err_clr)
        o_code_err <= 1'b0;
      if (multi_hot)
        o_bus_err <= 1'b1;
      else if (i_err_clr)
        o_bus_err <= 1'b0;
    end
  end

  // Snapshot FSM: collect a fresh value for every digit, then hold it until accepted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= COLLECT;
      o_valid <= 1'b0;
      o_value <= '0;
      o_blank <= '0;
      fresh   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (&fresh) begin
            // A capture on this same edge stays pending for the next snapshot
            o_value <= dig_val;
            o_blank <= dig_blk;
            o_valid <= 1'b1;
            fresh   <= fresh_set;
            state   <= HOLD;
          end else begin
            fresh <= fresh | fresh_set;
          end
        end
        HOLD: begin
          fresh <= fresh | fresh_set;
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= COLLECT;
          end
        end
      endcase
    end
  end

endmodule
